// File: rtl/ctrl_rx.sv
// ctrl_rx: serial frame receiver with a one-entry valid/ready output buffer; CTRL_RX_PARITY_EN adds per-line even parity
module ctrl_rx #(
  parameter int LENGTH = 32,
  parameter int LINES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LINES-1:0]  d,
  output logic [LENGTH-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              overflow,
  output logic              busy,
  output logic [15:0]       frame_cnt
`ifdef CTRL_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int N = LENGTH / LINES;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [LINES-1:0] d_q, d_rev;
  logic [LENGTH-1:0] sr;
  logic req, load, bad;
`ifdef CTRL_RX_PARITY_EN
  logic [LINES-1:0] par;
`else
  assign bad = 1'b0;
`endif
  assign busy = state != IDLE;
  assign load = req && !bad && (!valid || ready);
  // line 0 carries the most significant bit of each group
  always_comb begin
    d_rev = '0;
    for (int i = 0; i < LINES; i++) d_rev[i] = d_q[LINES-1-i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      d_q <= '0;
      sr <= '0;
      req <= 1'b0;
      data_out <= '0;
      valid <= 1'b0;
      overflow <= 1'b0;
      frame_cnt <= '0;
`ifdef CTRL_RX_PARITY_EN
      par <= '0;
      bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      d_q <= d;
      req <= 1'b0;
      overflow <= req && !bad && !load;
      valid <= load | (valid & ~ready);
      if (load) begin
        data_out <= sr;
        frame_cnt <= frame_cnt + 16'(frame_cnt != 16'hFFFF);
      end
`ifdef CTRL_RX_PARITY_EN
      parity_err <= req && bad;
`endif
      case (state)
        IDLE: if (d_q[0]) begin
          state <= SHIFT;
          cnt <= '0;
`ifdef CTRL_RX_PARITY_EN
          par <= '0;
`endif
        end
        SHIFT: begin
          sr <= (sr << LINES) | LENGTH'(d_rev);
          cnt <= cnt + CW'(1);
`ifdef CTRL_RX_PARITY_EN
          par <= par ^ d_q;
          if (cnt == CW'(N - 1)) state <= CHECK;
`else
          if (cnt == CW'(N - 1)) begin
            state <= IDLE;
            req <= 1'b1;
          end
`endif
        end
`ifdef CTRL_RX_PARITY_EN
        CHECK: begin
          state <= IDLE;
          req <= 1'b1;
          bad <= |(par ^ d_q);
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_rx.sv
// tb_ctrl_rx: randomized self-checking bench for ctrl_rx against a frame-level reference model
module tb_ctrl_rx;
`ifdef CTRL_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk = 0, rst = 0, ready = 1, ready4 = 1, d1 = 0;
  logic [3:0] d4 = '0;
  logic [31:0] data1, data4;
  logic valid1, ovf1, busy1, valid4, ovf4, busy4;
  logic [15:0] cnt1, cnt4;
`ifdef CTRL_RX_PARITY_EN
  logic perr1, perr4;
`endif
  int cyc = 0, n_vec = 0, n_err = 0;
  bit m_valid, m_ovf, m_perr, m_busy;
  logic [31:0] m_data = '0;
  int m_cnt = 0;
  logic [31:0] ld_word[int];
  bit ld_bad[int];
  bit bz[int];
  bit d1_at[int];
  logic [3:0] d4_at[int];
  logic [31:0] ld4[int];
  bit bz4[int];

  ctrl_rx #(.LENGTH(32), .LINES(1)) u1 (
    .clk(clk), .rst(rst), .d(d1), .data_out(data1), .valid(valid1), .ready(ready),
    .overflow(ovf1), .busy(busy1), .frame_cnt(cnt1)
`ifdef CTRL_RX_PARITY_EN
    , .parity_err(perr1)
`endif
  );
  ctrl_rx #(.LENGTH(32), .LINES(4)) u4 (
    .clk(clk), .rst(rst), .d(d4), .data_out(data4), .valid(valid4), .ready(ready4),
    .overflow(ovf4), .busy(busy4), .frame_cnt(cnt4)
`ifdef CTRL_RX_PARITY_EN
    , .parity_err(perr4)
`endif
  );

  always #5 clk = ~clk;

  // frame whose start bit is sampled at edge s; returns the next zero-gap start edge
  function automatic int plan1(int s, logic [31:0] w, bit bad);
    d1_at[s] = 1'b1;
    for (int k = 1; k <= 32; k++) d1_at[s+k] = w[32-k];
    if (PB == 1) d1_at[s+33] = (^w) ^ bad;
    for (int t = s + 1; t <= s + 32 + PB; t++) bz[t] = 1'b1;
    ld_word[s+34+PB] = w;
    ld_bad[s+34+PB] = bad;
    return s + 33 + PB;
  endfunction

  function automatic int plan4(int s, logic [31:0] w);
    logic [3:0] v, p;
    p = '0;
    d4_at[s] = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      for (int i = 0; i < 4; i++) v[i] = w[31-i-4*(k-1)];
      d4_at[s+k] = v;
      p = p ^ v;
    end
    if (PB == 1) d4_at[s+9] = p;
    for (int t = s + 1; t <= s + 8 + PB; t++) bz4[t] = 1'b1;
    ld4[s+10+PB] = w;
    return s + 9 + PB;
  endfunction

  task automatic tick();
    bit ld, ok;
    d1 = d1_at.exists(cyc + 1) ? d1_at[cyc+1] : 1'b0;
    d4 = d4_at.exists(cyc + 1) ? d4_at[cyc+1] : 4'b0;
    @(posedge clk);
    cyc++;
    m_ovf = 0;
    m_perr = 0;
    if (rst) begin
      ld = ld_word.exists(cyc) != 0;
      ok = ld ? !ld_bad[cyc] : 1'b0;
      if (ok && (!m_valid || ready)) begin
        m_data = ld_word[cyc];
        m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_ovf = ok;
        m_perr = ld && !ok;
        if (m_valid && ready) m_valid = 0;
      end
    end
    m_busy = bz.exists(cyc) != 0;
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_vec++;
    if ({valid1, ovf1, busy1, cnt1, data1, valid4, busy4, cnt4, data4} !== '0) begin
      n_err++;
      $display("FAIL reset: got v%b o%b b%b cnt%0d %h / v%b b%b cnt%0d %h, expected all zero",
               valid1, ovf1, busy1, cnt1, data1, valid4, busy4, cnt4, data4);
    end
    rst = 1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int s, stop, pulses = 0;
    ready = 1;
    s = cyc + 2;
    stop = plan1(s, 32'hF000_0000, 0) + 5;
    while (cyc < stop) begin
      tick();
      pulses += int'(valid1);
      n_vec++;
      if ({valid1, ovf1, busy1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL single @%0d: got v%b o%b b%b cnt%0d %h, expected v%b o%b b%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, cnt1, data1, m_valid, m_ovf, m_busy, m_cnt, m_data);
      end
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL single_pulse_width: got %0d valid cycles, expected 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int s, stop, r0 = -1, r1 = -1, ovfs = 0;
    bit pv = 0;
    ready = 1;
    s = plan1(cyc + 2, 32'hF0B4_0411, 0);
    s = plan1(s, 32'hF0B4_0211, 0);
    s = plan1(s, $urandom, 0);
    stop = plan1(s, $urandom, 0) + 5;
    while (cyc < stop) begin
      tick();
      if (valid1 && !pv) begin
        if (r0 < 0) r0 = cyc; else if (r1 < 0) r1 = cyc;
      end
      pv = valid1;
      ovfs += int'(ovf1);
      n_vec++;
      if ({valid1, ovf1, busy1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL back_to_back @%0d: got v%b o%b b%b cnt%0d %h, expected v%b o%b b%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, cnt1, data1, m_valid, m_ovf, m_busy, m_cnt, m_data);
      end
    end
    n_vec++;
    if (r1 - r0 !== 33 + PB || ovfs !== 0) begin
      n_err++;
      $display("FAIL back_to_back_spacing: got spacing %0d overflows %0d, expected %0d and 0", r1 - r0, ovfs, 33 + PB);
    end
  endtask

  task automatic test_overflow();
    int s, stop, c0, ovfs = 0;
    ready = 0;
    c0 = m_cnt;
    s = plan1(cyc + 2, 32'hF090_0000, 0);
    s = plan1(s, 32'hF090_0001, 0);
    stop = plan1(s, 32'hF0A0_0100, 0) + 5;
    while (cyc < stop) begin
      tick();
      ovfs += int'(ovf1);
      n_vec++;
      if ({valid1, ovf1, busy1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL overflow @%0d: got v%b o%b b%b cnt%0d %h, expected v%b o%b b%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, cnt1, data1, m_valid, m_ovf, m_busy, m_cnt, m_data);
      end
    end
    n_vec++;
    if (data1 !== 32'hF090_0000 || ovfs !== 2 || int'(cnt1) - c0 !== 1 || valid1 !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_hold: got %h ovf=%0d dcnt=%0d v%b, expected f0900000 2 1 v1",
               data1, ovfs, int'(cnt1) - c0, valid1);
    end
    ready = 1;
    tick();
    n_vec++;
    if (valid1 !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_drain: got valid %b, expected 0", valid1);
    end
  endtask

  task automatic test_lines4();
    int s, stop;
    bit ev, eb;
    s = plan4(cyc + 2, 32'hF0B4_0311);
    stop = plan4(s, $urandom) + 5;
    while (cyc < stop) begin
      tick();
      ev = ld4.exists(cyc) != 0;
      eb = bz4.exists(cyc) != 0;
      n_vec++;
      if (valid4 !== ev || busy4 !== eb || ovf4 !== 1'b0 || (ev && data4 !== ld4[cyc])) begin
        n_err++;
        $display("FAIL lines4 @%0d: got v%b b%b o%b %h, expected v%b b%b o0 %h",
                 cyc, valid4, busy4, ovf4, data4, ev, eb, ev ? ld4[cyc] : data4);
      end
    end
  endtask

  task automatic test_random();
    int s, stop;
    s = cyc + 2;
    for (int f = 0; f < 6; f++) s = plan1(s + $urandom_range(0, 3), $urandom, 0);
    stop = s + 6;
    while (cyc < stop) begin
      ready = $urandom_range(0, 3) != 0;
      tick();
      n_vec++;
      if ({valid1, ovf1, busy1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL random @%0d: got v%b o%b b%b cnt%0d %h, expected v%b o%b b%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, cnt1, data1, m_valid, m_ovf, m_busy, m_cnt, m_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s, stop;
    ready = 0;
    stop = plan1(cyc + 2, $urandom, 0) + 2;
    while (cyc < stop) tick();
    s = cyc + 2;
    void'(plan1(s, 32'hF0A0_0101, 0));
    while (cyc < s + 10) tick();
    n_vec++;
    if ({valid1, busy1} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_mid_pre: got v%b b%b, expected v1 b1", valid1, busy1);
    end
    rst = 0;
    #1;
    m_valid = 0; m_busy = 0; m_ovf = 0; m_perr = 0; m_cnt = 0; m_data = '0;
    ld_word.delete(); ld_bad.delete(); bz.delete(); d1_at.delete(); d4_at.delete(); ld4.delete(); bz4.delete();
    n_vec++;
    if ({valid1, busy1, ovf1, cnt1, data1} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got v%b b%b o%b cnt%0d %h, expected all zero", valid1, busy1, ovf1, cnt1, data1);
    end
    repeat (2) tick();
    rst = 1;
    ready = 1;
    stop = plan1(cyc + 2, 32'hF0A0_0101, 0) + 5;
    while (cyc < stop) begin
      tick();
      n_vec++;
      if ({valid1, ovf1, busy1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL reset_recover @%0d: got v%b o%b b%b cnt%0d %h, expected v%b o%b b%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, cnt1, data1, m_valid, m_ovf, m_busy, m_cnt, m_data);
      end
    end
  endtask

`ifdef CTRL_RX_PARITY_EN
  task automatic test_parity();
    int s, stop, perrs = 0;
    ready = 1;
    s = plan1(cyc + 2, 32'hF0B4_0210, 1);
    s = plan1(s, 32'hF0B4_0210, 0);
    s = plan1(s, $urandom, 1);
    stop = plan1(s, $urandom, 0) + 5;
    while (cyc < stop) begin
      ready = $urandom_range(0, 1) != 0;
      tick();
      perrs += int'(perr1);
      n_vec++;
      if ({valid1, ovf1, busy1, perr1, cnt1, data1} !== {m_valid, m_ovf, m_busy, m_perr, m_cnt[15:0], m_data}) begin
        n_err++;
        $display("FAIL parity @%0d: got v%b o%b b%b p%b cnt%0d %h, expected v%b o%b b%b p%b cnt%0d %h",
                 cyc, valid1, ovf1, busy1, perr1, cnt1, data1, m_valid, m_ovf, m_busy, m_perr, m_cnt, m_data);
      end
    end
    n_vec++;
    if (perrs !== 2) begin
      n_err++;
      $display("FAIL parity_count: got %0d parity_err pulses, expected 2", perrs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_lines4();
    test_random();
    test_reset_mid();
`ifdef CTRL_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
